// File: rtl/cordic_sequencer_if.sv
// Request/response handshake bundle for the CORDIC sin/cos sequencer.
// The master side issues angle requests and consumes results; the slave side is the sequencer.
interface cordic_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_angle;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_sin;
    logic [WIDTH-1:0] rsp_cos;
    logic             rsp_err;

    modport master (
        output req_valid, req_angle, rsp_ready,
        input  req_ready, rsp_valid, rsp_sin, rsp_cos, rsp_err
    );

    modport slave (
        input  req_valid, req_angle, rsp_ready,
        output req_ready, rsp_valid, rsp_sin, rsp_cos, rsp_err
    );
endinterface

// File: rtl/cordic_sequencer.sv
// Runs one sin/cos evaluation at a time: normalizer -> iterative CORDIC -> float converter.
// All outputs are registered; the FSM and every output register live in one clocked block.
module cordic_sequencer #(
    parameter int WIDTH      = 32,
    parameter int ITERATIONS = 24,
    parameter int ITER_W     = 5,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    cordic_sequencer_if.slave   bus,
    output logic [WIDTH-1:0]    norm_angle,
    input  logic [WIDTH-1:0]    norm_result,
    input  logic [2:0]          norm_flips,
    output logic                cordic_load,
    output logic [WIDTH-1:0]    cordic_z0,
    output logic                cordic_en,
    output logic [ITER_W-1:0]   cordic_iter,
    output logic [2:0]          flips_hold,
    input  logic [WIDTH-1:0]    conv_sin,
    input  logic [WIDTH-1:0]    conv_cos,
    output logic                busy,
    output logic [CNT_W-1:0]    op_count
);

    typedef enum logic [2:0] {IDLE, NORM, LOAD, ITER, CONV, RESP} state_t;

    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(ITERATIONS - 1);

    state_t                   state_q;
    logic signed [WIDTH-1:0]  norm_angle_q;
    logic signed [WIDTH-1:0]  z0_q;
    logic [2:0]               flips_q;
    logic                     err_q;
    logic                     load_q;
    logic                     en_q;
    logic [ITER_W-1:0]        iter_q;
    logic                     req_ready_q;
    logic                     rsp_valid_q;
    logic [WIDTH-1:0]         rsp_sin_q;
    logic [WIDTH-1:0]         rsp_cos_q;
    logic                     rsp_err_q;
    logic                     busy_q;
    logic [CNT_W-1:0]         op_count_q;

    logic [ITER_W-1:0]        iter_d;
    logic [CNT_W-1:0]         op_count_d;

    // Flips are a signed 3-bit quadrant count; only -2..+2 are meaningful downstream.
    function automatic logic flips_legal(input logic [2:0] f);
        return (f != 3'b011) && (f != 3'b100) && (f != 3'b101);
    endfunction

    assign iter_d     = iter_q + 1'b1;
    assign op_count_d = op_count_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            norm_angle_q <= '0;
            z0_q         <= '0;
            flips_q      <= '0;
            err_q        <= 1'b0;
            load_q       <= 1'b0;
            en_q         <= 1'b0;
            iter_q       <= '0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_sin_q    <= '0;
            rsp_cos_q    <= '0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            op_count_q   <= '0;
        end else if (flush) begin
            // Abort drops any pending response; latched data is left untouched.
            state_q     <= IDLE;
            load_q      <= 1'b0;
            en_q        <= 1'b0;
            iter_q      <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        norm_angle_q <= bus.req_angle;
                        req_ready_q  <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= NORM;
                    end
                end
                NORM: begin
                    z0_q    <= norm_result;
                    flips_q <= flips_legal(norm_flips) ? norm_flips : 3'b000;
                    err_q   <= !flips_legal(norm_flips);
                    load_q  <= 1'b1;
                    state_q <= LOAD;
                end
                LOAD: begin
                    load_q  <= 1'b0;
                    en_q    <= 1'b1;
                    iter_q  <= '0;
                    state_q <= ITER;
                end
                ITER: begin
                    if (iter_q == LAST_ITER) begin
                        en_q    <= 1'b0;
                        iter_q  <= '0;
                        state_q <= CONV;
                    end else begin
                        iter_q <= iter_d;
                    end
                end
                CONV: begin
                    rsp_sin_q   <= conv_sin;
                    rsp_cos_q   <= conv_cos;
                    rsp_err_q   <= err_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        op_count_q  <= op_count_d;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign norm_angle    = norm_angle_q;
    assign cordic_load   = load_q;
    assign cordic_z0     = z0_q;
    assign cordic_en     = en_q;
    assign cordic_iter   = iter_q;
    assign flips_hold    = flips_q;
    assign busy          = busy_q;
    assign op_count      = op_count_q;
    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_sin   = rsp_sin_q;
    assign bus.rsp_cos   = rsp_cos_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule
